// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types for the instruction-fetch stage.
package fetch_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
  typedef enum logic {RUN, WAIT_JUMP} fetch_state_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry FIFO of fetched words with synchronous clear and flop-backed head.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_push,
  input  fetch_entry_t i_din,
  input  logic         i_pop,
  output logic [CW-1:0] o_count,
  output fetch_entry_t o_head
);
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count;
  fetch_entry_t  r_mem [DEPTH];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_clr) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_din;
        r_wr        <= r_wr + 1'b1;
      end
      if (i_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd];
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC-driven instruction fetch with tag pipe, credit-limited issue and redirect handling.
// Optional FETCH_PERF_EN adds pop/stall/flush counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int IMEM_LATENCY = 1,
  parameter int DEPTH        = 4,
  parameter int ADDR_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pc_in,
  input  logic              jump_finish,
  output logic              pc_advance,
  input  logic              flush,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [31:0]       if_instr,
  output logic [31:0]       if_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  fetch_state_t r_state, w_state_nxt;
  logic [IMEM_LATENCY-1:0] r_tag_v;
  logic [31:0]             r_tag_pc [IMEM_LATENCY];
  logic [CW-1:0]           w_count;
  logic [CW:0]             w_inflight;
  logic                    w_issue, w_pop;
  fetch_entry_t            w_head;
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < IMEM_LATENCY; i++) w_inflight = w_inflight + (CW+1)'(r_tag_v[i]);
  end
  // credit counts only registered occupancy so a same-cycle pop never lets us overrun
  assign w_issue    = !rst && r_state == RUN && !flush && ({1'b0, w_count} + w_inflight) < (CW+1)'(DEPTH);
  assign imem_en    = w_issue;
  assign pc_advance = w_issue;
  assign imem_addr  = pc_in[ADDR_W-1:0];
  assign w_pop      = if_valid && if_ready;
  always_comb begin
    w_state_nxt = flush ? WAIT_JUMP : (r_state == WAIT_JUMP && jump_finish) ? RUN : r_state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_state_nxt;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag_v <= '0;
      for (int i = 0; i < IMEM_LATENCY; i++) r_tag_pc[i] <= '0;
    end else begin
      r_tag_v[0]  <= w_issue;
      r_tag_pc[0] <= pc_in;
      for (int i = 1; i < IMEM_LATENCY; i++) begin
        r_tag_v[i]  <= r_tag_v[i-1];
        r_tag_pc[i] <= r_tag_pc[i-1];
      end
      if (flush) r_tag_v <= '0;
    end
  end
  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (flush),
    .i_push  (r_tag_v[IMEM_LATENCY-1]),
    .i_din   ('{pc: r_tag_pc[IMEM_LATENCY-1], instr: imem_rdata}),
    .i_pop   (w_pop),
    .o_count (w_count),
    .o_head  (w_head)
  );
  assign if_valid = w_count != '0;
  assign if_instr = w_head.instr;
  assign if_pc    = w_head.pc;
`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (w_pop) perf_fetch_cnt <= perf_fetch_cnt + 1'b1;
      if (if_valid && !if_ready) perf_stall_cnt <= perf_stall_cnt + 1'b1;
      if (flush) perf_flush_cnt <= perf_flush_cnt + 1'b1;
    end
  end
`endif
endmodule
